// File: rtl/dmem_if.sv
// Request/response bundle between the memory stage (master) and the data
// memory responder (slave). Signal names keep their direction suffixes as
// seen from the responder.
interface dmem_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Y86-64 data memory responder. One 64-bit little-endian access per request;
// misaligned accesses are split into two word beats (BEAT0 on word w,
// BEAT1 on word w+1). Out-of-range addresses answer with rsp_err_o and
// never touch the array.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic  clk_i,
  input  logic  rstn_i,
  dmem_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [64:0] LIMIT = 65'(DEPTH_WORDS) << 3;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

  state_e          state_q, state_d;
  logic            we_q;
  logic [AW-1:0]   w_q;
  logic [2:0]      o_q;
  logic [63:0]     wdata_q;
  logic [63:0]     word0_q;
  logic [63:0]     rdata_q;
  logic            err_q;

  logic [63:0]     mem_q [DEPTH_WORDS];

  logic            accept;
  logic            addr_err;
  logic [AW-1:0]   w1;
  logic [63:0]     mem_w;
  logic [63:0]     mem_w1;
  logic [5:0]      sh_lo;
  logic [5:0]      sh_hi;

  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [7:0]      wr_mask;
  logic [63:0]     wr_data;

  // Range check done in 65 bits so addresses near 2^64 cannot wrap into range.
  assign addr_err = (({1'b0, bus.req_addr_i} + 65'd7) >= LIMIT);
  assign accept   = bus.req_valid_i && bus.req_ready_o;

  // Second word of a misaligned access; in range whenever o != 0 passed the check.
  assign w1     = w_q + AW'(1);
  assign mem_w  = mem_q[w_q];
  assign mem_w1 = mem_q[w1];
  // sh_lo = 8*o, sh_hi = 8*(8-o) (only meaningful for o != 0).
  assign sh_lo  = {o_q, 3'b000};
  assign sh_hi  = {3'(3'd0 - o_q), 3'b000};

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: defaulting state_d before the case keeps this purely combinational
  // (an unassigned path would infer a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = addr_err ? RESP : BEAT0;
      BEAT0:   state_d = (o_q == 3'd0) ? RESP : BEAT1;
      BEAT1:   state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and array write-port controls decoded from the current state.
  always_comb begin
    bus.req_ready_o = rstn_i && (state_q == IDLE);
    bus.rsp_valid_o = (state_q == RESP);
    wr_en   = 1'b0;
    wr_idx  = w_q;
    wr_mask = 8'h00;
    wr_data = 64'd0;
    if (we_q && !err_q) begin
      if (state_q == BEAT0) begin
        wr_en   = 1'b1;
        wr_idx  = w_q;
        wr_mask = 8'hFF << o_q;
        wr_data = wdata_q << sh_lo;
      end else if (state_q == BEAT1) begin
        wr_en   = 1'b1;
        wr_idx  = w1;
        wr_mask = ~(8'hFF << o_q);
        wr_data = wdata_q >> sh_hi;
      end
    end
  end

  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;

  // Request capture and read-data assembly across the beats.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      we_q    <= 1'b0;
      w_q     <= '0;
      o_q     <= 3'd0;
      wdata_q <= 64'd0;
      word0_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          we_q    <= bus.req_we_i;
          w_q     <= bus.req_addr_i[AW+2:3];
          o_q     <= bus.req_addr_i[2:0];
          wdata_q <= bus.req_wdata_i;
          err_q   <= addr_err;
          rdata_q <= 64'd0;
        end
        BEAT0: if (!we_q) begin
          word0_q <= mem_w;
          if (o_q == 3'd0) rdata_q <= mem_w;
        end
        BEAT1: if (!we_q) begin
          rdata_q <= (word0_q >> sh_lo) | (mem_w1 << sh_hi);
        end
        default: ;
      endcase
    end
  end

  // Byte-lane writes into the array.
  // NOTE: the array has no reset; clearing it would turn a RAM into a huge
  // flop bank, and software never relies on initial contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_mask[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus ();

  dmem_responder #(.DEPTH_WORDS(1024)) dut (
    .clk_i  (clk),
    .rstn_i (rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Drive a request, wait for accept, then count cycles until rsp_valid_o.
  // Entered and left at #1 after a rising edge.
  task automatic issue(input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, output int lat);
    int guard;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_valid_i = 1'b1;
    guard = 0;
    while (!bus.req_ready_o && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    lat = 1;
    while (!bus.rsp_valid_o && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  // Sample the response and complete the handshake.
  task automatic complete(output logic [63:0] rdata, output logic err);
    rdata = bus.rsp_rdata_o;
    err   = bus.rsp_err_o;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rdata, output logic err, output int lat);
    issue(we, addr, wdata, lat);
    complete(rdata, err);
  endtask

  task automatic test_reset;
    total++; if (bus.req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus.req_ready_o); end
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.rsp_valid_o); end
    total++; if (bus.rsp_rdata_o !== 64'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata_o); end
    total++; if (bus.rsp_err_o !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.rsp_err_o); end
  endtask

  task automatic test_aligned;
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h100, 64'h1122334455667788, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL aligned_wr_lat: got %0d want 2", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL aligned_wr_err: got %b want 0", er); end
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL aligned_wr_rdata: got %h want 0", rd); end
    do_req(1'b0, 64'h100, 64'h0, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL aligned_rd_lat: got %0d want 2", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL aligned_rd_err: got %b want 0", er); end
    total++; if (rd !== 64'h1122334455667788) begin bad++; $display("FAIL aligned_rd_data: got %h want 1122334455667788", rd); end
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL aligned_valid_drop: got %b want 0", bus.rsp_valid_o); end
    total++; if (bus.req_ready_o !== 1'b1) begin bad++; $display("FAIL aligned_ready_back: got %b want 1", bus.req_ready_o); end
  endtask

  task automatic test_misaligned;
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h200, 64'h0, rd, er, lat);
    do_req(1'b1, 64'h208, 64'h0, rd, er, lat);
    do_req(1'b1, 64'h203, 64'h0807060504030201, rd, er, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL mis_wr_lat: got %0d want 3", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL mis_wr_err: got %b want 0", er); end
    do_req(1'b0, 64'h200, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h0504030201000000) begin bad++; $display("FAIL mis_word0: got %h want 0504030201000000", rd); end
    do_req(1'b0, 64'h208, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h0000000000080706) begin bad++; $display("FAIL mis_word1: got %h want 0000000000080706", rd); end
    do_req(1'b0, 64'h203, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h0807060504030201) begin bad++; $display("FAIL mis_rd_data: got %h want 0807060504030201", rd); end
    total++; if (lat !== 3) begin bad++; $display("FAIL mis_rd_lat: got %0d want 3", lat); end
  endtask

  task automatic test_boundary;
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h1FF8, 64'hCAFEF00DDEADBEEF, rd, er, lat);
    do_req(1'b0, 64'h1FF8, 64'h0, rd, er, lat);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL top_rd_err: got %b want 0", er); end
    total++; if (rd !== 64'hCAFEF00DDEADBEEF) begin bad++; $display("FAIL top_rd_data: got %h want cafef00ddeadbeef", rd); end
    do_req(1'b0, 64'h1FF9, 64'h0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL oob_rd_err: got %b want 1", er); end
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL oob_rd_data: got %h want 0", rd); end
    total++; if (lat !== 1) begin bad++; $display("FAIL oob_rd_lat: got %0d want 1", lat); end
    do_req(1'b1, 64'h1FF9, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL oob_wr_err: got %b want 1", er); end
    do_req(1'b0, 64'h1FF8, 64'h0, rd, er, lat);
    total++; if (rd !== 64'hCAFEF00DDEADBEEF) begin bad++; $display("FAIL oob_wr_untouched: got %h want cafef00ddeadbeef", rd); end
    do_req(1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL wrap_err: got %b want 1", er); end
    total++; if (rd !== 64'd0) begin bad++; $display("FAIL wrap_rdata: got %h want 0", rd); end
  endtask

  task automatic test_stall;
    logic [63:0] rd; logic er; int lat;
    issue(1'b0, 64'h100, 64'h0, lat);
    // A competing write to the same word must not be accepted while stalled.
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 64'h100;
    bus.req_wdata_i = 64'h0;
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (bus.rsp_valid_o !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.rsp_valid_o); end
      total++; if (bus.rsp_rdata_o !== 64'h1122334455667788) begin bad++; $display("FAIL stall_rdata[%0d]: got %h want 1122334455667788", i, bus.rsp_rdata_o); end
      total++; if (bus.rsp_err_o !== 1'b0) begin bad++; $display("FAIL stall_err[%0d]: got %b want 0", i, bus.rsp_err_o); end
      total++; if (bus.req_ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.req_ready_o); end
    end
    bus.req_valid_i = 1'b0;
    complete(rd, er);
    do_req(1'b0, 64'h100, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h1122334455667788) begin bad++; $display("FAIL stall_no_accept: got %h want 1122334455667788", rd); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h300, 64'hA5A5A5A5A5A5A5A5, rd, er, lat);
    do_req(1'b1, 64'h308, 64'h5A5A5A5A5A5A5A5A, rd, er, lat);
    // Reset while a read response is being held.
    issue(1'b0, 64'h308, 64'h0, lat);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", bus.rsp_valid_o); end
    total++; if (bus.rsp_rdata_o !== 64'd0) begin bad++; $display("FAIL rst_resp_rdata: got %h want 0", bus.rsp_rdata_o); end
    total++; if (bus.req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_resp_ready: got %b want 0", bus.req_ready_o); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // Misaligned write aborted right after BEAT0.
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 64'h305;
    bus.req_wdata_i = 64'h1111111111111111;
    bus.req_valid_i = 1'b1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rst_beat_valid: got %b want 0", bus.rsp_valid_o); end
    total++; if (bus.rsp_err_o !== 1'b0) begin bad++; $display("FAIL rst_beat_err: got %b want 0", bus.rsp_err_o); end
    total++; if (bus.req_ready_o !== 1'b0) begin bad++; $display("FAIL rst_beat_ready: got %b want 0", bus.req_ready_o); end
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 64'h308, 64'h0, rd, er, lat);
    total++; if (rd !== 64'h5A5A5A5A5A5A5A5A) begin bad++; $display("FAIL rst_word1_kept: got %h want 5a5a5a5a5a5a5a5a", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL rst_word1_err: got %b want 0", er); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 64'd0;
    bus.req_wdata_i = 64'd0;
    bus.rsp_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_aligned();
    test_misaligned();
    test_boundary();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
